// File: rtl/fft_frame_arbiter.sv
// Frame-atomic arbiter: grants one source for N samples onto a shared FFT and tags FFT output frames with source ID.
// Grant 1 cycle after request; data/return paths combinational, ready passed through. Define FFT_ARB_FIXED_PRIO_EN for fixed priority.

module fft_arb_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module fft_frame_arbiter #(
  parameter int WIDTH         = 32,
  parameter int OW            = 48,
  parameter int NUM_SRC       = 3,
  parameter int N             = 256,
  parameter int ID_FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*WIDTH-1:0]   s_tdata,
  input  logic [NUM_SRC-1:0]         s_tvalid,
  output logic [NUM_SRC-1:0]         s_tready,
  output logic [WIDTH-1:0]           m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  input  logic [OW-1:0]              r_tdata,
  input  logic                       r_tvalid,
  input  logic                       r_tlast,
  output logic                       r_tready,
  output logic [OW-1:0]              o_tdata,
  output logic                       o_tvalid,
  output logic                       o_tlast,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] o_tid,
  input  logic                       o_tready,
  output logic                       busy,
  output logic                       err_orphan
);
  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] pick;
  logic           pick_vld;
  logic           push, pop;
  logic           fifo_full, fifo_empty;
  logic [IDW-1:0] fifo_head;

`ifdef FFT_ARB_FIXED_PRIO_EN
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (s_tvalid[i]) begin
        pick     = IDW'(i);
        pick_vld = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0]         rr_ptr;
  logic [2*NUM_SRC-1:0]   req_rot;
  logic [IDW:0]           rr_sum;

  // Rotate the doubled request vector so index 0 is rr_ptr; first set bit wins.
  always_comb begin
    req_rot  = {s_tvalid, s_tvalid} >> rr_ptr;
    pick     = '0;
    pick_vld = 1'b0;
    rr_sum   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!pick_vld && req_rot[i]) begin
        rr_sum = {1'b0, rr_ptr} + (IDW+1)'(i);
        if (rr_sum >= (IDW+1)'(NUM_SRC)) rr_sum = rr_sum - (IDW+1)'(NUM_SRC);
        pick     = rr_sum[IDW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (pick == IDW'(NUM_SRC - 1)) ? '0 : pick + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    grant_d  = grant_q;
    push     = 1'b0;
    s_tready = '0;
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        // fifo_full is this cycle's value, so a same-cycle pop does not unblock the grant.
        if (pick_vld && !fifo_full) begin
          grant_d = pick;
          push    = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        busy = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant_q == IDW'(i)) begin
            m_tdata     = s_tdata[i*WIDTH +: WIDTH];
            m_tvalid    = s_tvalid[i];
            s_tready[i] = m_tready;
          end
        end
        m_tlast = (count_q == CW'(N - 1));
        if (m_tvalid && m_tready) begin
          if (m_tlast) begin
            count_d = '0;
            state_d = IDLE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      grant_q <= grant_d;
    end
  end

  assign pop = r_tvalid && o_tready && r_tlast && !fifo_empty;

  fft_arb_id_fifo #(
    .W     (IDW),
    .DEPTH (ID_FIFO_DEPTH)
  ) u_id_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (grant_d),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign o_tdata  = r_tdata;
  assign o_tvalid = r_tvalid;
  assign o_tlast  = r_tlast;
  assign r_tready = o_tready;
  assign o_tid    = fifo_empty ? '0 : fifo_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_orphan <= 1'b0;
    end else if (r_tvalid && fifo_empty) begin
      err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed bench for fft_frame_arbiter: NUM_SRC=3, N=16, ID_FIFO_DEPTH=4.
module tb_fft_frame_arbiter;
  localparam int WIDTH   = 32;
  localparam int OW      = 48;
  localparam int NUM_SRC = 3;
  localparam int N       = 16;
  localparam int DEPTH   = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_SRC*WIDTH-1:0] s_tdata;
  logic [NUM_SRC-1:0]       s_tvalid;
  logic [NUM_SRC-1:0]       s_tready;
  logic [WIDTH-1:0]         m_tdata;
  logic                     m_tvalid;
  logic                     m_tready;
  logic                     m_tlast;
  logic [OW-1:0]            r_tdata;
  logic                     r_tvalid;
  logic                     r_tlast;
  logic                     r_tready;
  logic [OW-1:0]            o_tdata;
  logic                     o_tvalid;
  logic                     o_tlast;
  logic [1:0]               o_tid;
  logic                     o_tready;
  logic                     busy;
  logic                     err_orphan;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fft_frame_arbiter #(
    .WIDTH         (WIDTH),
    .OW            (OW),
    .NUM_SRC       (NUM_SRC),
    .N             (N),
    .ID_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .r_tdata    (r_tdata),
    .r_tvalid   (r_tvalid),
    .r_tlast    (r_tlast),
    .r_tready   (r_tready),
    .o_tdata    (o_tdata),
    .o_tvalid   (o_tvalid),
    .o_tlast    (o_tlast),
    .o_tid      (o_tid),
    .o_tready   (o_tready),
    .busy       (busy),
    .err_orphan (err_orphan)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    rst_n    = 1'b0;
    s_tdata  = '0;
    s_tvalid = '0;
    m_tready = 1'b0;
    r_tdata  = '0;
    r_tvalid = 1'b0;
    r_tlast  = 1'b0;
    o_tready = 1'b0;
    #2;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_o_tvalid", o_tvalid, 0);
    chk("rst_err_orphan", err_orphan, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    // Single source: src1 streams 0..15
    m_tready = 1'b1;
    s_tvalid = 3'b010;
    s_tdata[WIDTH +: WIDTH] = 32'd0;
    #1;
    chk("t1_idle_s_tready", s_tready, 0);
    chk("t1_idle_m_tvalid", m_tvalid, 0);
    chk("t1_idle_busy", busy, 0);
    tick;
    for (int b = 0; b < N; b++) begin
      s_tdata[WIDTH +: WIDTH] = 32'(b);
      #1;
      chk("t1_m_tdata", m_tdata, 64'(b));
      chk("t1_s_tready", s_tready, 3'b010);
      chk("t1_m_tlast", m_tlast, 64'(b == N - 1));
      chk("t1_busy", busy, 1);
      tick;
    end
    s_tvalid = '0;
    #1;
    chk("t1_done_busy", busy, 0);

    // FFT returns one frame: all beats tagged with src1
    o_tready = 1'b1;
    r_tvalid = 1'b1;
    for (int b = 0; b < N; b++) begin
      r_tdata = 48'(64'h5000_0000 + 64'(b));
      r_tlast = (b == N - 1);
      #1;
      chk("t1_o_tid", o_tid, 1);
      chk("t1_o_tdata", o_tdata, 64'h5000_0000 + 64'(b));
      chk("t1_o_tlast", o_tlast, 64'(b == N - 1));
      chk("t1_o_tvalid", o_tvalid, 1);
      chk("t1_r_tready", r_tready, 1);
      tick;
    end
    r_tvalid = 1'b0;
    r_tlast  = 1'b0;
    #1;
    chk("t1_fifo_empty_tid", o_tid, 0);
    chk("t1_no_orphan", err_orphan, 0);

    // All sources valid, FFT held off: grants 0,1,2,0 then FIFO full
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) s_tdata[k*WIDTH +: WIDTH] = 32'((k + 1) * 32'h1000_0000);
    s_tvalid = 3'b111;
    m_tready = 1'b1;
    o_tready = 1'b0;
    #1;
    for (int f = 0; f < DEPTH; f++) begin
      chk("t2_bubble_busy", busy, 0);
      chk("t2_bubble_s_tready", s_tready, 0);
      tick;
      for (int b = 0; b < N; b++) begin
        chk("t2_grant", s_tready, 64'(3'b001 << (f % 3)));
        chk("t2_m_tdata", m_tdata, 64'(((f % 3) + 1) * 32'h1000_0000));
        chk("t2_m_tlast", m_tlast, 64'(b == N - 1));
        tick;
      end
    end
    for (int c = 0; c < 3; c++) begin
      chk("t4_full_s_tready", s_tready, 0);
      chk("t4_full_busy", busy, 0);
      tick;
    end
    r_tvalid = 1'b1;
    r_tlast  = 1'b1;
    o_tready = 1'b1;
    #1;
    chk("t4_head_src0", o_tid, 0);
    chk("t4_pop_cycle_blocked", s_tready, 0);
    tick;
    r_tvalid = 1'b0;
    r_tlast  = 1'b0;
    #1;
    chk("t4_idle_after_pop", busy, 0);
    chk("t4_head_src1", o_tid, 1);
    tick;
    chk("t4_fifth_grant", s_tready, 3'b010);
    chk("t4_fifth_busy", busy, 1);

    // src0 alone, m_tready toggling, tvalid dropped for 5 cycles mid-frame
    s_tvalid = '0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    sent = 0;
    for (int c = 0; c < 200 && sent < N; c++) begin
      m_tready = (c % 2 == 0);
      s_tvalid = (c >= 8 && c < 13) ? 3'b000 : 3'b001;
      s_tdata[0 +: WIDTH] = 32'(32'hC0DE_0000 + sent);
      #1;
      if (m_tvalid && m_tready) begin
        chk("t3_m_tdata", m_tdata, 64'(32'hC0DE_0000 + sent));
        chk("t3_m_tlast", m_tlast, 64'(sent == N - 1));
        sent++;
      end
      tick;
    end
    s_tvalid = '0;
    m_tready = 1'b1;
    #1;
    chk("t3_handshakes", 64'(sent), 64'(N));
    chk("t3_done_busy", busy, 0);

    // Pop the remaining frame, then an orphan beat
    o_tready = 1'b1;
    r_tvalid = 1'b1;
    r_tlast  = 1'b1;
    chk("t5_head_src0", o_tid, 0);
    chk("t5_pre_orphan", err_orphan, 0);
    tick;
    r_tlast = 1'b0;
    #1;
    chk("t5_empty_tid", o_tid, 0);
    tick;
    r_tvalid = 1'b0;
    #1;
    chk("t5_orphan_set", err_orphan, 1);
    tick;
    tick;
    chk("t5_orphan_sticky", err_orphan, 1);

    // rr_ptr=1 after src0 grant: with src0 and src2 requesting, src2 wins
    s_tdata[0 +: WIDTH]       = 32'hAAAA_0000;
    s_tdata[2*WIDTH +: WIDTH] = 32'hBBBB_0000;
    s_tvalid = 3'b101;
    m_tready = 1'b1;
    tick;
    chk("t6_rr_grant2", s_tready, 3'b100);
    chk("t6_m_tdata_src2", m_tdata, 32'hBBBB_0000);
    for (int b = 0; b < 7; b++) tick;
    chk("t6_beat7_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_arst_s_tready", s_tready, 0);
    chk("t6_arst_m_tvalid", m_tvalid, 0);
    chk("t6_arst_m_tlast", m_tlast, 0);
    chk("t6_arst_busy", busy, 0);
    chk("t6_arst_err_orphan", err_orphan, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("t6_rr_reset_grant0", s_tready, 3'b001);
    chk("t6_m_tdata_src0", m_tdata, 32'hAAAA_0000);
    for (int b = 0; b < N; b++) begin
      chk("t6_m_tlast", m_tlast, 64'(b == N - 1));
      tick;
    end
    chk("t6_frame_end_busy", busy, 0);
    s_tvalid = '0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
